// File: rtl/n64_ctrl_resp.sv
// n64_ctrl_resp: controller side of the N64 joybus. Decodes the console command
// byte from the open-drain line and answers with the poll word or the identity.
module n64_ctrl_resp #(
  parameter int CLK_FREQ      = 25_000_000,
  parameter int RESP_DELAY_US = 2,
  parameter int IDLE_US       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  output logic        drive_low,
  input  logic [31:0] buttons_in,
  input  logic        buttons_valid,
  output logic [7:0]  cmd_out,
  output logic        cmd_valid,
  output logic        busy
);
  localparam int US     = CLK_FREQ / 1_000_000;
  localparam int MAX_US = (IDLE_US > 8) ? IDLE_US : 8;
  localparam int CW     = $clog2(MAX_US * US + 1) + 1;

  localparam logic [CW-1:0] C_ZERO     = CW'(0);
  localparam logic [CW-1:0] C_ONE      = CW'(1);
  localparam logic [CW-1:0] C_SAMPLE   = CW'(2 * US);
  localparam logic [CW-1:0] C_LOW_MAX  = CW'(4 * US);
  localparam logic [CW-1:0] C_BIT_END  = CW'(4 * US - 1);
  localparam logic [CW-1:0] C_LOW1_END = CW'(US - 1);
  localparam logic [CW-1:0] C_LOW0_END = CW'(3 * US - 1);
  localparam logic [CW-1:0] C_STOP_END = CW'(2 * US - 1);
  localparam logic [CW-1:0] C_GAP_END  = CW'(RESP_DELAY_US * US - 1);
  localparam logic [CW-1:0] C_IDLE_END = CW'(IDLE_US * US - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RX_BIT, S_RX_WAIT, S_RX_STOP, S_GAP,
    S_TX_LOW, S_TX_HIGH, S_TX_STOP, S_IGNORE
  } state_t;

  state_t          state_r;
  logic [1:0]      sync_r;
  logic            line_r;
  logic [CW-1:0]   cnt_r;
  logic [5:0]      bit_cnt_r;
  logic [7:0]      rx_sr_r;
  logic [31:0]     tx_sr_r;
  logic [31:0]     shadow_r;
  logic            drive_low_r;
  logic [7:0]      cmd_out_r;
  logic            cmd_valid_r;
  logic            busy_r;
  logic            din_s;
  logic            fall_s;

  assign din_s     = sync_r[1];
  assign fall_s    = line_r & ~din_s;
  assign drive_low = drive_low_r;
  assign cmd_out   = cmd_out_r;
  assign cmd_valid = cmd_valid_r;
  assign busy      = busy_r;

  // Two-stage line synchroniser plus previous-level register for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= 2'b11;
      line_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[0], din};
      line_r <= din_s;
    end
  end

  // Button shadow; a snapshot taken in the same cycle sees the old word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_r <= 32'h0000_0000;
    end else if (buttons_valid) begin
      shadow_r <= buttons_in;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Receive/transmit sequencer with registered line drive and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      cnt_r       <= C_ZERO;
      bit_cnt_r   <= 6'd0;
      rx_sr_r     <= 8'h00;
      tx_sr_r     <= 32'h0000_0000;
      drive_low_r <= 1'b0;
      cmd_out_r   <= 8'h00;
      cmd_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      cmd_valid_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          drive_low_r <= 1'b0;
          if (fall_s) begin
            state_r   <= S_RX_BIT;
            cnt_r     <= C_ONE;
            bit_cnt_r <= 6'd0;
            busy_r    <= 1'b1;
          end
        end
        S_RX_BIT: begin
          cnt_r <= cnt_r + C_ONE;
          if (cnt_r == C_SAMPLE) begin
            rx_sr_r   <= {rx_sr_r[6:0], din_s};
            bit_cnt_r <= bit_cnt_r + 6'd1;
            if (din_s) begin
              state_r <= S_RX_WAIT;
              cnt_r   <= C_ZERO;
            end
          end else if (cnt_r > C_SAMPLE) begin
            if (din_s) begin
              state_r <= S_RX_WAIT;
              cnt_r   <= C_ZERO;
            end else if (cnt_r >= C_LOW_MAX) begin
              state_r <= S_IGNORE;
              cnt_r   <= C_ZERO;
            end
          end
        end
        S_RX_WAIT: begin
          if (fall_s) begin
            cnt_r   <= C_ONE;
            state_r <= (bit_cnt_r == 6'd8) ? S_RX_STOP : S_RX_BIT;
          end else if (cnt_r >= C_IDLE_END) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + C_ONE;
          end
        end
        S_RX_STOP: begin
          cnt_r <= cnt_r + C_ONE;
          if (din_s) begin
            cmd_valid_r <= 1'b1;
            cmd_out_r   <= rx_sr_r;
            cnt_r       <= C_ZERO;
            case (rx_sr_r)
              8'h01: begin
                tx_sr_r   <= shadow_r;
                bit_cnt_r <= 6'd32;
                state_r   <= S_GAP;
              end
              8'h00, 8'hFF: begin
                tx_sr_r   <= {24'h05_0002, 8'h00};
                bit_cnt_r <= 6'd24;
                state_r   <= S_GAP;
              end
              default: state_r <= S_IGNORE;
            endcase
          end else if (cnt_r >= C_LOW_MAX) begin
            state_r <= S_IGNORE;
            cnt_r   <= C_ZERO;
          end
        end
        S_GAP: begin
          if (cnt_r == C_GAP_END) begin
            state_r     <= S_TX_LOW;
            drive_low_r <= 1'b1;
            cnt_r       <= C_ZERO;
          end else begin
            cnt_r <= cnt_r + C_ONE;
          end
        end
        S_TX_LOW: begin
          cnt_r <= cnt_r + C_ONE;
          if (cnt_r == (tx_sr_r[31] ? C_LOW1_END : C_LOW0_END)) begin
            drive_low_r <= 1'b0;
            state_r     <= S_TX_HIGH;
          end
        end
        S_TX_HIGH: begin
          if (cnt_r == C_BIT_END) begin
            cnt_r       <= C_ZERO;
            drive_low_r <= 1'b1;
            if (bit_cnt_r == 6'd1) begin
              state_r <= S_TX_STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r - 6'd1;
              tx_sr_r   <= {tx_sr_r[30:0], 1'b0};
              state_r   <= S_TX_LOW;
            end
          end else begin
            cnt_r <= cnt_r + C_ONE;
          end
        end
        S_TX_STOP: begin
          if (cnt_r == C_STOP_END) begin
            drive_low_r <= 1'b0;
            state_r     <= S_IDLE;
            busy_r      <= 1'b0;
          end else begin
            cnt_r <= cnt_r + C_ONE;
          end
        end
        S_IGNORE: begin
          drive_low_r <= 1'b0;
          if (!din_s) begin
            cnt_r <= C_ZERO;
          end else if (cnt_r >= C_IDLE_END) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + C_ONE;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          drive_low_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_n64_ctrl_resp.sv
// Randomized bench for n64_ctrl_resp: a console model sends command bytes and
// a line monitor decodes the reply against a reply table and shadow-word model.
`timescale 1ns/1ps
module tb_n64_ctrl_resp;
  logic        clk = 1'b0;
  logic        reset;
  logic        con_low;
  logic        din;
  logic        drive_low;
  logic [31:0] buttons_in;
  logic        buttons_valid;
  logic [7:0]  cmd_out;
  logic        cmd_valid;
  logic        busy;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] shadow_m;

  n64_ctrl_resp #(.CLK_FREQ(25_000_000), .RESP_DELAY_US(2), .IDLE_US(8)) dut (
    .clk(clk), .reset(reset), .din(din), .drive_low(drive_low),
    .buttons_in(buttons_in), .buttons_valid(buttons_valid),
    .cmd_out(cmd_out), .cmd_valid(cmd_valid), .busy(busy)
  );

  always #20 clk = ~clk;
  assign din = ~(con_low | drive_low);

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input bit b);
    int low;
    low = (b ? 25 : 75) + int'($urandom_range(0, 6)) - 3;
    con_low = 1'b1;
    repeat (low) @(negedge clk);
    con_low = 1'b0;
    repeat (100 - low) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    con_low = 1'b1;
    repeat (25) @(negedge clk);
    con_low = 1'b0;
  endtask

  task automatic set_buttons(input logic [31:0] w);
    buttons_in    = w;
    buttons_valid = 1'b1;
    @(negedge clk);
    buttons_valid = 1'b0;
    shadow_m      = w;
  endtask

  task automatic wait_cmd_valid(output bit seen);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (cmd_valid) seen = 1'b1;
    end
  endtask

  // watch n cycles; report how many cmd_valid and drive_low cycles were seen
  task automatic quiet(input int n, output int cv, output int dl);
    cv = 0; dl = 0;
    repeat (n) begin
      @(negedge clk);
      if (cmd_valid) cv++;
      if (drive_low) dl++;
    end
  endtask

  // send a command, then decode and check the reply; optionally reload the
  // buttons at the start of reply bit upd_bit
  task automatic run_cmd(input logic [7:0] cmd, input int upd_bit, input logic [31:0] upd_val);
    logic [31:0] exp_w, got_w;
    int exp_n, n, lo, hi, bad_lo, bad_per, stop_lo, t, cv, dl;
    bit seen;
    exp_n = (cmd == 8'h01) ? 32 : ((cmd == 8'h00 || cmd == 8'hFF) ? 24 : 0);
    exp_w = (cmd == 8'h01) ? shadow_m : 32'h0005_0002;
    send_byte(cmd);
    wait_cmd_valid(seen);
    chk_eq("cmd_valid", 32'(seen), 32'd1);
    chk_eq("cmd_out", 32'(cmd_out), 32'(cmd));
    if (exp_n == 0) begin
      quiet(150, cv, dl);
      chk_eq("ignore_busy", 32'(busy), 32'd1);
      quiet(100, cv, t);
      chk_eq("ignore_quiet_drive", 32'(dl + t), 32'd0);
      chk_eq("ignore_idle", 32'(busy), 32'd0);
      return;
    end
    t = 0;
    while (!drive_low && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk_eq("resp_gap", 32'(t), 32'd50);
    got_w = 32'h0; n = 0; bad_lo = 0; bad_per = 0; stop_lo = 0;
    for (int k = 0; k < 40; k++) begin
      lo = 0;
      while (drive_low && lo < 200) begin
        if (k == upd_bit && lo == 0) begin
          buttons_in    = upd_val;
          buttons_valid = 1'b1;
        end else begin
          buttons_valid = 1'b0;
        end
        @(negedge clk);
        lo++;
      end
      buttons_valid = 1'b0;
      hi = 0;
      while (!drive_low && hi < 150) begin
        @(negedge clk);
        hi++;
      end
      if (hi >= 150) begin
        stop_lo = lo;
        break;
      end
      got_w = {got_w[30:0], lo < 50};
      n++;
      if (lo != ((lo < 50) ? 25 : 75)) bad_lo++;
      if (lo + hi != 100) bad_per++;
    end
    chk_eq("resp_bits", 32'(n), 32'(exp_n));
    chk_eq("resp_word", got_w, exp_w);
    chk_eq("resp_low_widths", 32'(bad_lo), 32'd0);
    chk_eq("resp_bit_period", 32'(bad_per), 32'd0);
    chk_eq("resp_stop_low", 32'(stop_lo), 32'd50);
    chk_eq("resp_busy_end", 32'(busy), 32'd0);
    if (upd_bit >= 0) shadow_m = upd_val;
  endtask

  initial begin
    int cv, dl, t;
    bit seen;
    logic [7:0] rc;
    reset = 1'b1; con_low = 1'b0; buttons_in = 32'h0; buttons_valid = 1'b0;
    shadow_m = 32'h0;
    repeat (3) @(negedge clk);
    chk_eq("rst_drive_low", 32'(drive_low), 32'd0);
    chk_eq("rst_cmd_out", 32'(cmd_out), 32'd0);
    chk_eq("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    set_buttons(32'h8000_0001);
    run_cmd(8'h01, -1, 32'h0);
    run_cmd(8'h00, -1, 32'h0);
    run_cmd(8'hFF, -1, 32'h0);
    run_cmd(8'h13, -1, 32'h0);

    // line held low for 10 us in the middle of a byte
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    con_low = 1'b1;
    repeat (250) @(negedge clk);
    con_low = 1'b0;
    quiet(300, cv, dl);
    chk_eq("stuck_low_no_cmd", 32'(cv), 32'd0);
    chk_eq("stuck_low_no_drive", 32'(dl), 32'd0);
    chk_eq("stuck_low_idle", 32'(busy), 32'd0);
    run_cmd(8'h01, -1, 32'h0);

    // reset pulsed during reply bit 10
    set_buttons(32'h1234_5678);
    send_byte(8'h01);
    wait_cmd_valid(seen);
    chk_eq("rst_mid_cmd_valid", 32'(seen), 32'd1);
    t = 0;
    while (!drive_low && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (9 * 100 + 10) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_eq("rst_mid_release", 32'(drive_low), 32'd0);
    chk_eq("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    shadow_m = 32'h0;
    repeat (5) @(negedge clk);
    run_cmd(8'h01, -1, 32'h0);

    // buttons reloaded during a reply only affect the next reply
    set_buttons(32'h0F0F_A5A5);
    run_cmd(8'h01, 5, 32'hDEAD_BEEF);
    run_cmd(8'h01, -1, 32'h0);

    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) set_buttons($urandom);
      case ($urandom_range(0, 3))
        0: rc = 8'h01;
        1: rc = 8'h00;
        2: rc = 8'hFF;
        default: rc = 8'($urandom_range(2, 254));
      endcase
      run_cmd(rc, (rc == 8'h01 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, 31)) : -1, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
